bp_cce_simple_responder: RTL and testbench
==========================================

Name: bp_cce_simple_responder

Overview:
- CCE-side endpoint of the LCE-CCE coherence interface for one LCE (I$ or D$ slice); it is the other end of the core's req/resp/cmd links.
- Accepts LCE requests, fetches or stores through a memory command/response channel, issues LCE commands, and collects coherence acks.
- Serves one transaction at a time; used in single-core and unit-test tiles in place of the microcoded CCE.

Parameters:
- paddr_width_p, 40, physical address width
- block_width_p, 512, cache block width in bits
- lce_id_width_p, 2, LCE id width
- lce_assoc_p, 8, ways; way id width = clog2(lce_assoc_p)
- ack_timeout_p, 1024, cycles to wait for coh_ack before flagging an error

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- lce_req_i  in  req_width_lp  packed bp_cce_simple_req_s {msg_type, lce_id, addr, lru_way, uc_data[63:0], size}
- lce_req_v_i  in  1  request valid
- lce_req_yumi_o  out  1  request consumed
- lce_resp_i  in  resp_width_lp  packed {msg_type, lce_id, addr}
- lce_resp_v_i  in  1  response valid
- lce_resp_yumi_o  out  1  response consumed
- lce_cmd_o  out  cmd_width_lp  packed {msg_type, dst_id, addr, way_id, state, data[block_width_p-1:0]}
- lce_cmd_v_o  out  1  command valid
- lce_cmd_ready_i  in  1  command sink ready
- mem_cmd_o  out  mem_cmd_width_lp  {op(rd/wr), addr, size, data[63:0]}
- mem_cmd_v_o  out  1  memory command valid
- mem_cmd_ready_i  in  1  memory ready
- mem_resp_i  in  mem_resp_width_lp  {op, addr, data[block_width_p-1:0]}
- mem_resp_v_i  in  1  memory response valid
- mem_resp_yumi_o  out  1  memory response consumed
- error_o  out  1  sticky: ack timeout or unexpected resp

Behaviour:
- Reset: state e_ready; all _v_o, _yumi_o, error_o = 0; captured-request register cleared. Async assert, synchronous deassert use.
- Handshakes: valid-ready on outputs (payload held stable while v_o & ~ready); yumi on inputs (yumi only when v_i high, same cycle).
- FSM:
  - e_ready: lce_req_yumi_o = lce_req_v_i; capture req; go e_mem_cmd.
  - e_mem_cmd: mem_cmd_v_o=1; miss_load/miss_store/uc_load -> op rd, block-aligned addr (uc: exact addr, size); uc_store -> op wr with uc_data. On ready -> e_mem_resp.
  - e_mem_resp: mem_resp_yumi_o = mem_resp_v_i; capture data -> e_send_cmd.
  - e_send_cmd: lce_cmd_v_o=1; miss_load -> e_data_and_tag, state E; miss_store -> state M; uc_load -> e_uc_data (data word in low 64 bits); uc_store -> e_uc_st_done; way_id = captured lru_way; dst_id = captured lce_id. On ready: misses -> e_wait_ack, uc -> e_ready.
  - e_wait_ack: lce_resp_yumi_o = lce_resp_v_i; coh_ack with matching addr -> e_ready; other msg or addr mismatch -> consume, set error_o, stay. Timeout counter (clog2(ack_timeout_p+1) bits, cleared on entry) reaching ack_timeout_p sets error_o, returns e_ready.
- Latency: request accept to mem_cmd_v_o = 1 cycle; mem_resp accept to lce_cmd_v_o = 1 cycle; min miss turnaround req->ready = 5 cycles with all sinks ready.
- lce_resp outside e_wait_ack: not consumed (yumi 0).
- Back-to-back: new request accepted the cycle after return to e_ready (no same-cycle bypass).
- Mid-operation reset: FSM aborts to e_ready, in-flight outputs drop same cycle.
- error_o clears only on reset.

Optional Feature:
- BP_CCE_SIMPLE_PERF_EN: adds outputs miss_count_o[31:0], uc_count_o[31:0], busy_cycles_o[31:0]; counters increment at lce_cmd handshake (miss vs uc) and every cycle FSM != e_ready; saturate at all-ones; reset to 0. Without macro: ports and counters absent.

Decomposition:
- bp_cce_simple_pkg: req/resp/cmd msg_type enums, coherence state enum (I,S,E,M), mem op enum, packed-struct declare macros and width macros, FSM state enum.
- Sub-module bp_cce_simple_ack_timer: counter with clear/enable/expired.

Test Plan:
- Miss load addr 0x8000_0040, lru_way 3 -> mem rd addr 0x8000_0040; resp data pattern A -> lce_cmd e_data_and_tag way 3 state E data A; coh_ack -> ready, error_o 0.
- Uc store addr 0x1000, data 0xDEAD_BEEF size 4 -> mem wr same; mem ack -> e_uc_st_done; no ack wait.
- lce_cmd_ready_i held 0 for 7 cycles -> lce_cmd_v_o stays 1, payload unchanged; accepted on cycle 8.
- No coh_ack, ack_timeout_p=16 -> error_o rises 16 cycles after entering e_wait_ack, FSM returns e_ready.
- Reset asserted during e_mem_resp -> all valids/yumis 0 immediately; next request handled normally.
- PERF_EN: 3 misses + 2 uc ops -> miss_count_o=3, uc_count_o=2.

Source files
------------

// File: rtl/bp_cce_simple_pkg.sv
// rtl/bp_cce_simple_pkg.sv - message/state enums and payload width helpers for the simple CCE responder
package bp_cce_simple_pkg;

    typedef enum logic [1:0] {
        e_miss_load  = 2'd0,
        e_miss_store = 2'd1,
        e_uc_load    = 2'd2,
        e_uc_store   = 2'd3
    } req_msg_e;

    typedef enum logic [1:0] {
        e_coh_ack      = 2'd0,
        e_resp_wb      = 2'd1,
        e_resp_null_wb = 2'd2
    } resp_msg_e;

    typedef enum logic [1:0] {
        e_cmd_data_and_tag = 2'd0,
        e_cmd_uc_data      = 2'd1,
        e_cmd_uc_st_done   = 2'd2,
        e_cmd_invalidate   = 2'd3
    } cmd_msg_e;

    typedef enum logic [1:0] {
        e_coh_I = 2'd0,
        e_coh_S = 2'd1,
        e_coh_E = 2'd2,
        e_coh_M = 2'd3
    } coh_state_e;

    typedef enum logic {
        e_mem_rd = 1'b0,
        e_mem_wr = 1'b1
    } mem_op_e;

    typedef enum logic [2:0] {
        e_ready    = 3'd0,
        e_mem_cmd  = 3'd1,
        e_mem_resp = 3'd2,
        e_send_cmd = 3'd3,
        e_wait_ack = 3'd4
    } state_e;

    // Size fields carry log2 of the byte count (0 = 1B ... 6 = 64B).
    localparam int msg_width_gp   = 2;
    localparam int size_width_gp  = 3;
    localparam int uc_width_gp    = 64;

    function automatic int way_width(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

    function automatic int req_width(input int paddr, input int lce, input int way);
        return msg_width_gp + lce + paddr + way + uc_width_gp + size_width_gp;
    endfunction

    function automatic int resp_width(input int paddr, input int lce);
        return msg_width_gp + lce + paddr;
    endfunction

    function automatic int cmd_width(input int paddr, input int lce, input int way, input int block);
        return msg_width_gp + lce + paddr + way + 2 + block;
    endfunction

    function automatic int mem_cmd_width(input int paddr);
        return 1 + paddr + size_width_gp + uc_width_gp;
    endfunction

    function automatic int mem_resp_width(input int paddr, input int block);
        return 1 + paddr + block;
    endfunction

endpackage

// File: rtl/bp_cce_simple_ack_timer.sv
// rtl/bp_cce_simple_ack_timer.sv - coherence-ack wait counter with clear/enable/expired
module bp_cce_simple_ack_timer #(
    parameter int limit_p = 1024,
    localparam int width_lp = $clog2(limit_p + 1)
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [width_lp-1:0] limit_lp = width_lp'(limit_p);
    localparam logic [width_lp-1:0] last_lp  = width_lp'(limit_p - 1);

    logic [width_lp-1:0] count_q;

    // Fires in the cycle whose clock edge brings the count to the limit.
    assign expired_o = en_i & (count_q == last_lp);

    // Count enabled cycles, holding at the limit until cleared.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != limit_lp)) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/bp_cce_simple_responder.sv
// rtl/bp_cce_simple_responder.sv - single-transaction CCE endpoint for one LCE (optional BP_CCE_SIMPLE_PERF_EN counters)
module bp_cce_simple_responder
    import bp_cce_simple_pkg::*;
#(
    parameter int paddr_width_p  = 40,
    parameter int block_width_p  = 512,
    parameter int lce_id_width_p = 2,
    parameter int lce_assoc_p    = 8,
    parameter int ack_timeout_p  = 1024,
    localparam int way_id_width_lp   = way_width(lce_assoc_p),
    localparam int req_width_lp      = req_width(paddr_width_p, lce_id_width_p, way_id_width_lp),
    localparam int resp_width_lp     = resp_width(paddr_width_p, lce_id_width_p),
    localparam int cmd_width_lp      = cmd_width(paddr_width_p, lce_id_width_p, way_id_width_lp, block_width_p),
    localparam int mem_cmd_width_lp  = mem_cmd_width(paddr_width_p),
    localparam int mem_resp_width_lp = mem_resp_width(paddr_width_p, block_width_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [req_width_lp-1:0]      lce_req_i,
    input  logic                         lce_req_v_i,
    output logic                         lce_req_yumi_o,
    input  logic [resp_width_lp-1:0]     lce_resp_i,
    input  logic                         lce_resp_v_i,
    output logic                         lce_resp_yumi_o,
    output logic [cmd_width_lp-1:0]      lce_cmd_o,
    output logic                         lce_cmd_v_o,
    input  logic                         lce_cmd_ready_i,
    output logic [mem_cmd_width_lp-1:0]  mem_cmd_o,
    output logic                         mem_cmd_v_o,
    input  logic                         mem_cmd_ready_i,
    input  logic [mem_resp_width_lp-1:0] mem_resp_i,
    input  logic                         mem_resp_v_i,
    output logic                         mem_resp_yumi_o,
    output logic                         error_o
`ifdef BP_CCE_SIMPLE_PERF_EN
    ,
    output logic [31:0]                  miss_count_o,
    output logic [31:0]                  uc_count_o,
    output logic [31:0]                  busy_cycles_o
`endif
);

    localparam int block_offset_lp = $clog2(block_width_p / 8);
    localparam logic [size_width_gp-1:0] block_size_lp = size_width_gp'(block_offset_lp);

    typedef struct packed {
        req_msg_e                   msg_type;
        logic [lce_id_width_p-1:0]  lce_id;
        logic [paddr_width_p-1:0]   addr;
        logic [way_id_width_lp-1:0] lru_way;
        logic [uc_width_gp-1:0]     uc_data;
        logic [size_width_gp-1:0]   size;
    } req_s;

    typedef struct packed {
        resp_msg_e                  msg_type;
        logic [lce_id_width_p-1:0]  lce_id;
        logic [paddr_width_p-1:0]   addr;
    } resp_s;

    typedef struct packed {
        cmd_msg_e                   msg_type;
        logic [lce_id_width_p-1:0]  dst_id;
        logic [paddr_width_p-1:0]   addr;
        logic [way_id_width_lp-1:0] way_id;
        coh_state_e                 state;
        logic [block_width_p-1:0]   data;
    } cmd_s;

    typedef struct packed {
        mem_op_e                    op;
        logic [paddr_width_p-1:0]   addr;
        logic [size_width_gp-1:0]   size;
        logic [uc_width_gp-1:0]     data;
    } mem_cmd_s;

    typedef struct packed {
        mem_op_e                    op;
        logic [paddr_width_p-1:0]   addr;
        logic [block_width_p-1:0]   data;
    } mem_resp_s;

    req_s      req_in, req_q;
    resp_s     resp_in;
    mem_resp_s mem_resp_in;
    cmd_s      cmd_out;
    mem_cmd_s  mem_cmd_out;
    state_e    state_q;
    logic [block_width_p-1:0] data_q;
    logic [block_width_p-1:0] resp_data;
    logic error_q;
    logic is_miss, is_uc_load, is_uc_store;
    logic ack_expired, ack_good;
    logic unused_fields;

    assign req_in      = lce_req_i;
    assign resp_in     = lce_resp_i;
    assign mem_resp_in = mem_resp_i;
    assign unused_fields = ^{mem_resp_in.op, mem_resp_in.addr, resp_in.lce_id};

    assign is_uc_load  = (req_q.msg_type == e_uc_load);
    assign is_uc_store = (req_q.msg_type == e_uc_store);
    assign is_miss     = ~is_uc_load & ~is_uc_store;
    assign ack_good    = (resp_in.msg_type == e_coh_ack) && (resp_in.addr == req_q.addr);

    // Valids decode from the state register; yumis are same-cycle and drop while reset is held.
    assign lce_req_yumi_o  = reset_n_i & (state_q == e_ready)    & lce_req_v_i;
    assign mem_resp_yumi_o = reset_n_i & (state_q == e_mem_resp) & mem_resp_v_i;
    assign lce_resp_yumi_o = reset_n_i & (state_q == e_wait_ack) & lce_resp_v_i;
    assign mem_cmd_v_o     = (state_q == e_mem_cmd);
    assign lce_cmd_v_o     = (state_q == e_send_cmd);
    assign error_o         = error_q;
    assign lce_cmd_o       = cmd_out;
    assign mem_cmd_o       = mem_cmd_out;

    // Misses fetch whole blocks; uncached ops use exact address and size.
    always_comb begin
        mem_cmd_out.op   = is_uc_store ? e_mem_wr : e_mem_rd;
        mem_cmd_out.addr = is_miss ? {req_q.addr[paddr_width_p-1:block_offset_lp], {block_offset_lp{1'b0}}}
                                   : req_q.addr;
        mem_cmd_out.size = is_miss ? block_size_lp : req_q.size;
        mem_cmd_out.data = is_uc_store ? req_q.uc_data : '0;
    end

    // Uncached loads return one word in the low bits; store acks carry no data.
    always_comb begin
        resp_data = mem_resp_in.data;
        if (is_uc_load) begin
            resp_data = block_width_p'(mem_resp_in.data[uc_width_gp-1:0]);
        end else if (is_uc_store) begin
            resp_data = '0;
        end
    end

    // Command type and granted coherence state follow the captured request type.
    always_comb begin
        cmd_out.msg_type = e_cmd_data_and_tag;
        cmd_out.dst_id   = req_q.lce_id;
        cmd_out.addr     = req_q.addr;
        cmd_out.way_id   = req_q.lru_way;
        cmd_out.state    = e_coh_E;
        cmd_out.data     = data_q;
        case (req_q.msg_type)
            e_miss_store: cmd_out.state = e_coh_M;
            e_uc_load: begin
                cmd_out.msg_type = e_cmd_uc_data;
                cmd_out.state    = e_coh_I;
            end
            e_uc_store: begin
                cmd_out.msg_type = e_cmd_uc_st_done;
                cmd_out.state    = e_coh_I;
            end
            default: ;
        endcase
    end

    bp_cce_simple_ack_timer #(
        .limit_p (ack_timeout_p)
    ) ack_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (state_q != e_wait_ack),
        .en_i      (state_q == e_wait_ack),
        .expired_o (ack_expired)
    );

    // Transaction sequencer: request -> memory -> LCE command -> optional ack wait.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            req_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                e_ready: begin
                    if (lce_req_v_i) begin
                        req_q   <= req_in;
                        state_q <= e_mem_cmd;
                    end
                end
                e_mem_cmd: begin
                    if (mem_cmd_ready_i) state_q <= e_mem_resp;
                end
                e_mem_resp: begin
                    if (mem_resp_v_i) begin
                        data_q  <= resp_data;
                        state_q <= e_send_cmd;
                    end
                end
                e_send_cmd: begin
                    if (lce_cmd_ready_i) state_q <= is_miss ? e_wait_ack : e_ready;
                end
                e_wait_ack: begin
                    if (lce_resp_v_i && ack_good) begin
                        state_q <= e_ready;
                    end else begin
                        if (lce_resp_v_i) error_q <= 1'b1;
                        if (ack_expired) begin
                            error_q <= 1'b1;
                            state_q <= e_ready;
                        end
                    end
                end
                default: state_q <= e_ready;
            endcase
        end
    end

`ifdef BP_CCE_SIMPLE_PERF_EN
    logic [31:0] miss_count_q, uc_count_q, busy_cycles_q;
    logic cmd_fire;

    assign cmd_fire      = lce_cmd_v_o & lce_cmd_ready_i;
    assign miss_count_o  = miss_count_q;
    assign uc_count_o    = uc_count_q;
    assign busy_cycles_o = busy_cycles_q;

    // Saturating event counters: command handshakes by class, and non-idle cycles.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            miss_count_q  <= '0;
            uc_count_q    <= '0;
            busy_cycles_q <= '0;
        end else begin
            if (cmd_fire && is_miss && (miss_count_q != '1)) miss_count_q <= miss_count_q + 32'd1;
            if (cmd_fire && !is_miss && (uc_count_q != '1)) uc_count_q <= uc_count_q + 32'd1;
            if ((state_q != e_ready) && (busy_cycles_q != '1)) busy_cycles_q <= busy_cycles_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_cce_simple_responder.sv
// tb/tb_bp_cce_simple_responder.sv - vector-table and sequence checks for bp_cce_simple_responder
module tb_bp_cce_simple_responder;
    import bp_cce_simple_pkg::*;

    localparam int PADDR = 40;
    localparam int BLOCK = 512;
    localparam int LCE   = 2;
    localparam int ASSOC = 8;
    localparam int WAY   = 3;
    localparam int TMO   = 16;

    localparam logic [BLOCK-1:0] PAT_A = {8{64'h0123_4567_89AB_CDEF}};
    localparam logic [BLOCK-1:0] PAT_B = {16{32'hC001_D00D}};
    localparam logic [BLOCK-1:0] PAT_C = {{7{64'hFFFF_FFFF_FFFF_FFFF}}, 64'h1122_3344_5566_7788};
    localparam logic [BLOCK-1:0] PAT_D = {8{64'h5555_AAAA_5555_AAAA}};

    typedef struct packed {
        req_msg_e msg_type; logic [LCE-1:0] lce_id; logic [PADDR-1:0] addr;
        logic [WAY-1:0] lru_way; logic [63:0] uc_data; logic [2:0] size;
    } req_s;
    typedef struct packed {
        resp_msg_e msg_type; logic [LCE-1:0] lce_id; logic [PADDR-1:0] addr;
    } resp_s;
    typedef struct packed {
        cmd_msg_e msg_type; logic [LCE-1:0] dst_id; logic [PADDR-1:0] addr;
        logic [WAY-1:0] way_id; coh_state_e state; logic [BLOCK-1:0] data;
    } cmd_s;
    typedef struct packed {
        mem_op_e op; logic [PADDR-1:0] addr; logic [2:0] size; logic [63:0] data;
    } mem_cmd_s;
    typedef struct packed {
        mem_op_e op; logic [PADDR-1:0] addr; logic [BLOCK-1:0] data;
    } mem_resp_s;

    typedef struct {
        req_msg_e msg; logic [LCE-1:0] lce; logic [PADDR-1:0] addr; logic [WAY-1:0] way;
        logic [63:0] uc_data; logic [2:0] size; logic [BLOCK-1:0] mresp;
        mem_op_e e_op; logic [PADDR-1:0] e_maddr; logic [2:0] e_msize; logic [63:0] e_mdata;
        cmd_msg_e e_cmsg; coh_state_e e_state; logic [BLOCK-1:0] e_cdata;
    } vec_t;

    vec_t vecs [4];

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    req_s lce_req;
    logic lce_req_v, lce_req_yumi;
    resp_s lce_resp;
    logic lce_resp_v, lce_resp_yumi;
    logic [$bits(cmd_s)-1:0] lce_cmd_w;
    logic lce_cmd_v, lce_cmd_ready;
    logic [$bits(mem_cmd_s)-1:0] mem_cmd_w;
    logic mem_cmd_v, mem_cmd_ready;
    mem_resp_s mem_resp;
    logic mem_resp_v, mem_resp_yumi;
    logic error;
`ifdef BP_CCE_SIMPLE_PERF_EN
    logic [31:0] miss_count, uc_count, busy_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_cce_simple_responder #(
        .paddr_width_p  (PADDR),
        .block_width_p  (BLOCK),
        .lce_id_width_p (LCE),
        .lce_assoc_p    (ASSOC),
        .ack_timeout_p  (TMO)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .lce_req_i       (lce_req),
        .lce_req_v_i     (lce_req_v),
        .lce_req_yumi_o  (lce_req_yumi),
        .lce_resp_i      (lce_resp),
        .lce_resp_v_i    (lce_resp_v),
        .lce_resp_yumi_o (lce_resp_yumi),
        .lce_cmd_o       (lce_cmd_w),
        .lce_cmd_v_o     (lce_cmd_v),
        .lce_cmd_ready_i (lce_cmd_ready),
        .mem_cmd_o       (mem_cmd_w),
        .mem_cmd_v_o     (mem_cmd_v),
        .mem_cmd_ready_i (mem_cmd_ready),
        .mem_resp_i      (mem_resp),
        .mem_resp_v_i    (mem_resp_v),
        .mem_resp_yumi_o (mem_resp_yumi),
        .error_o         (error)
`ifdef BP_CCE_SIMPLE_PERF_EN
        ,
        .miss_count_o    (miss_count),
        .uc_count_o      (uc_count),
        .busy_cycles_o   (busy_cycles)
`endif
    );

    task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic cmd_s exp_cmd(input int i);
        return '{vecs[i].e_cmsg, vecs[i].lce, vecs[i].addr, vecs[i].way, vecs[i].e_state, vecs[i].e_cdata};
    endfunction

    function automatic logic is_miss_vec(input int i);
        return (vecs[i].msg == e_miss_load) || (vecs[i].msg == e_miss_store);
    endfunction

    // Request through memory round trip; ends sampling the first lce_cmd cycle.
    task automatic start_txn(input int i);
        mem_cmd_s mc;
        @(negedge clk);
        lce_req = '{vecs[i].msg, vecs[i].lce, vecs[i].addr, vecs[i].way, vecs[i].uc_data, vecs[i].size};
        lce_req_v = 1'b1;
        #1 chk("req_yumi", lce_req_yumi, 1'b1);
        @(negedge clk);
        lce_req_v = 1'b0;
        #1 chk("mem_cmd_v", mem_cmd_v, 1'b1);
        mc = '{vecs[i].e_op, vecs[i].e_maddr, vecs[i].e_msize, vecs[i].e_mdata};
        chk("mem_cmd", mem_cmd_w, mc);
        @(negedge clk);
        mem_resp = '{vecs[i].e_op, vecs[i].e_maddr, vecs[i].mresp};
        mem_resp_v = 1'b1;
        #1 chk("mem_resp_yumi", mem_resp_yumi, 1'b1);
        chk("mem_cmd_v_drop", mem_cmd_v, 1'b0);
        @(negedge clk);
        mem_resp_v = 1'b0;
        #1 chk("lce_cmd_v", lce_cmd_v, 1'b1);
        chk("lce_cmd", lce_cmd_w, exp_cmd(i));
    endtask

    task automatic finish_txn(input int i);
        @(negedge clk);
        #1 chk("lce_cmd_v_drop", lce_cmd_v, 1'b0);
        if (is_miss_vec(i)) begin
            lce_resp = '{e_coh_ack, vecs[i].lce, vecs[i].addr};
            lce_resp_v = 1'b1;
            #1 chk("ack_yumi", lce_resp_yumi, 1'b1);
            @(negedge clk);
            lce_resp_v = 1'b0;
        end
        #1 chk("error_clear", error, 1'b0);
    endtask

    task automatic run_txn(input int i);
        start_txn(i);
        finish_txn(i);
    endtask

    initial begin
        vecs[0] = '{e_miss_load, 2'd1, 40'h00_8000_0040, 3'd3, 64'h0, 3'd0, PAT_A,
                    e_mem_rd, 40'h00_8000_0040, 3'd6, 64'h0, e_cmd_data_and_tag, e_coh_E, PAT_A};
        vecs[1] = '{e_miss_store, 2'd2, 40'h12_3456_789A, 3'd5, 64'h0, 3'd0, PAT_B,
                    e_mem_rd, 40'h12_3456_7880, 3'd6, 64'h0, e_cmd_data_and_tag, e_coh_M, PAT_B};
        vecs[2] = '{e_uc_load, 2'd0, 40'h00_0000_2004, 3'd6, 64'hFFFF_0000_FFFF_0000, 3'd3, PAT_C,
                    e_mem_rd, 40'h00_0000_2004, 3'd3, 64'h0, e_cmd_uc_data, e_coh_I,
                    512'h1122_3344_5566_7788};
        vecs[3] = '{e_uc_store, 2'd3, 40'h00_0000_1000, 3'd0, 64'hDEAD_BEEF, 3'd2, PAT_D,
                    e_mem_wr, 40'h00_0000_1000, 3'd2, 64'hDEAD_BEEF, e_cmd_uc_st_done, e_coh_I, '0};

        lce_req = '0; lce_req_v = 1'b0;
        lce_resp = '0; lce_resp_v = 1'b0;
        mem_resp = '0; mem_resp_v = 1'b0;
        mem_cmd_ready = 1'b1; lce_cmd_ready = 1'b1;

        // Reset state, including yumis held low with valids asserted.
        @(negedge clk);
        lce_req_v = 1'b1; lce_resp_v = 1'b1; mem_resp_v = 1'b1;
        #1 chk("rst_req_yumi", lce_req_yumi, 1'b0);
        chk("rst_resp_yumi", lce_resp_yumi, 1'b0);
        chk("rst_mem_yumi", mem_resp_yumi, 1'b0);
        chk("rst_cmd_v", lce_cmd_v, 1'b0);
        chk("rst_mem_cmd_v", mem_cmd_v, 1'b0);
        chk("rst_error", error, 1'b0);
        lce_req_v = 1'b0; lce_resp_v = 1'b0; mem_resp_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // lce_resp is ignored while idle.
        @(negedge clk);
        lce_resp = '{e_coh_ack, 2'd1, 40'h00_8000_0040};
        lce_resp_v = 1'b1;
        #1 chk("idle_resp_yumi", lce_resp_yumi, 1'b0);
        lce_resp_v = 1'b0;

        for (int i = 0; i < 4; i++) run_txn(i);

        // Command backpressure for 7 cycles, accepted on the 8th.
        lce_cmd_ready = 1'b0;
        start_txn(0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 chk("bp_cmd_v", lce_cmd_v, 1'b1);
            chk("bp_cmd_hold", lce_cmd_w, exp_cmd(0));
        end
        @(negedge clk);
        lce_cmd_ready = 1'b1;
        #1 chk("bp_cmd_v8", lce_cmd_v, 1'b1);
        finish_txn(0);

        // Ack with wrong address: consumed, sticky error, correct ack still completes.
        start_txn(1);
        @(negedge clk);
        lce_resp = '{e_coh_ack, vecs[1].lce, vecs[1].addr ^ 40'h40};
        lce_resp_v = 1'b1;
        #1 chk("bad_ack_yumi", lce_resp_yumi, 1'b1);
        @(negedge clk);
        lce_resp = '{e_coh_ack, vecs[1].lce, vecs[1].addr};
        #1 chk("bad_ack_err", error, 1'b1);
        chk("good_ack_yumi", lce_resp_yumi, 1'b1);
        @(negedge clk);
        lce_resp_v = 1'b0;
        #1 chk("err_sticky", error, 1'b1);

        // Reset in e_mem_resp drops everything at once.
        @(negedge clk);
        lce_req = '{vecs[2].msg, vecs[2].lce, vecs[2].addr, vecs[2].way, vecs[2].uc_data, vecs[2].size};
        lce_req_v = 1'b1;
        #1 chk("mr_req_yumi", lce_req_yumi, 1'b1);
        @(negedge clk);
        lce_req_v = 1'b0;
        #1 chk("mr_mem_cmd_v", mem_cmd_v, 1'b1);
        @(negedge clk);
        mem_resp = '{e_mem_rd, vecs[2].addr, vecs[2].mresp};
        mem_resp_v = 1'b1;
        #1 chk("mr_mem_yumi", mem_resp_yumi, 1'b1);
        reset_n = 1'b0;
        lce_req_v = 1'b1; lce_resp_v = 1'b1;
        #1 chk("mr_mem_yumi_rst", mem_resp_yumi, 1'b0);
        chk("mr_req_yumi_rst", lce_req_yumi, 1'b0);
        chk("mr_resp_yumi_rst", lce_resp_yumi, 1'b0);
        chk("mr_cmd_v_rst", lce_cmd_v, 1'b0);
        chk("mr_mem_cmd_v_rst", mem_cmd_v, 1'b0);
        chk("mr_err_rst", error, 1'b0);
        lce_req_v = 1'b0; lce_resp_v = 1'b0; mem_resp_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Three misses and two uncached ops after reset.
        run_txn(0);
        run_txn(2);
        run_txn(1);
        run_txn(3);
        run_txn(0);
`ifdef BP_CCE_SIMPLE_PERF_EN
        chk("perf_miss", miss_count, 32'd3);
        chk("perf_uc", uc_count, 32'd2);
`endif

        // No ack: error rises 16 cycles after entering e_wait_ack and FSM returns to e_ready.
        start_txn(0);
        @(negedge clk);
        #1 chk("tmo_err_k0", error, 1'b0);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            #1 chk($sformatf("tmo_err_k%0d", k), error, (k == TMO) ? 1'b1 : 1'b0);
        end
        lce_resp = '{e_coh_ack, vecs[0].lce, vecs[0].addr};
        lce_resp_v = 1'b1;
        lce_req = '{vecs[3].msg, vecs[3].lce, vecs[3].addr, vecs[3].way, vecs[3].uc_data, vecs[3].size};
        lce_req_v = 1'b1;
        #1 chk("tmo_resp_yumi", lce_resp_yumi, 1'b0);
        chk("tmo_req_yumi", lce_req_yumi, 1'b1);
        @(negedge clk);
        lce_req_v = 1'b0; lce_resp_v = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
